// File: rtl/dct_transpose_buffer_if.sv
// Handshake bundle between the row-pass DCT, the transpose buffer and the column-pass DCT.
// slave = transpose buffer view, master = surrounding stages view.
interface dct_transpose_buffer_if #(
  parameter int W = 16,
  parameter int N = 8
);
  logic [N*W-1:0] in_row;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] out_col;
  logic           out_valid;
  logic           out_ready;
  logic           out_first;
  logic           out_last;

  modport slave (
    input  in_row, in_valid, out_ready,
    output in_ready, out_col, out_valid, out_first, out_last
  );

  modport master (
    output in_row, in_valid, out_ready,
    input  in_ready, out_col, out_valid, out_first, out_last
  );
endinterface

// File: rtl/dct_transpose_buffer.sv
// Ping-pong 8x8 transpose memory: rows written from the row-pass DCT, columns read by the column pass.
// Lane k owns row k of both banks, so a column read is every lane selecting the same element.
module dct_transpose_lane #(
  parameter int W  = 16,
  parameter int N  = 8,
  parameter int AW = 3
) (
  input  logic           clk,
  input  logic           we,
  input  logic           wr_sel,
  input  logic [N*W-1:0] row,
  input  logic           rd_sel,
  input  logic [AW-1:0]  rd_col,
  output logic [W-1:0]   q
);
  // Storage is deliberately not reset; out_col is only meaningful with out_valid.
  logic [1:0][N-1:0][W-1:0] mem;

  always_ff @(posedge clk) begin
    if (we) mem[wr_sel] <= row;
  end

  assign q = mem[rd_sel][rd_col];
endmodule

module dct_transpose_buffer #(
  parameter int W = 16,
  parameter int N = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  dct_transpose_buffer_if.slave bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST = AW'(N-1);

  logic [1:0]           bank_full;
  logic                 wr_sel, rd_sel;
  logic [AW-1:0]        wr_row, rd_col;
  logic                 wr_fire, rd_fire;
  logic [1:0]           set_full, clr_full;
  logic [N-1:0][W-1:0]  col;

  assign bus.in_ready  = !bank_full[wr_sel];
  assign bus.out_valid = bank_full[rd_sel];
  assign bus.out_first = bus.out_valid && (rd_col == '0);
  assign bus.out_last  = bus.out_valid && (rd_col == LAST);
  assign bus.out_col   = col;

  assign wr_fire = bus.in_valid && bus.in_ready;
  assign rd_fire = bus.out_valid && bus.out_ready;

  // Set and clear always target different banks: the write bank is never full.
  always_comb begin
    set_full = '0;
    clr_full = '0;
    if (wr_fire && wr_row == LAST) set_full[wr_sel] = 1'b1;
    if (rd_fire && rd_col == LAST) clr_full[rd_sel] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_full <= '0;
      wr_sel    <= 1'b0;
      rd_sel    <= 1'b0;
      wr_row    <= '0;
      rd_col    <= '0;
    end else begin
      bank_full <= (bank_full | set_full) & ~clr_full;
      if (wr_fire) begin
        if (wr_row == LAST) begin
          wr_row <= '0;
          wr_sel <= ~wr_sel;
        end else begin
          wr_row <= wr_row + 1'b1;
        end
      end
      if (rd_fire) begin
        if (rd_col == LAST) begin
          rd_col <= '0;
          rd_sel <= ~rd_sel;
        end else begin
          rd_col <= rd_col + 1'b1;
        end
      end
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_lane
    dct_transpose_lane #(.W(W), .N(N), .AW(AW)) u_lane (
      .clk    (clk),
      .we     (wr_fire && (wr_row == AW'(k))),
      .wr_sel (wr_sel),
      .row    (bus.in_row),
      .rd_sel (rd_sel),
      .rd_col (rd_col),
      .q      (col[k])
    );
  end
endmodule
